alu_arbiter: RTL and testbench

//  Shares the single clocked 16-bit ALU between two requesters: port 0 (main datapath)
//  and port 1 (address/PC unit). Round-robin arbitration; latches the winner's operands
//  and op, drives the ALU for its latency, captures OutputData/Zero, returns a one-cycle Ack.

---
 rtl/alu_arbiter_if.sv | 25 ++
 rtl/alu_arbiter.sv | 63 ++++++
 tb/tb_alu_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester handshakes, shared result and ALU drive/return signals
interface alu_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OP_WIDTH = 3
);
  logic                Req0, Req1;
  logic [OP_WIDTH-1:0] Op0, Op1;
  logic [WIDTH-1:0]    A0, B0, A1, B1;
  logic                Ack0, Ack1;
  logic [WIDTH-1:0]    ResultOut;
  logic                ZeroOut;
  logic                Busy;
  logic [WIDTH-1:0]    ALUIn1, ALUIn2;
  logic [OP_WIDTH-1:0] ALUOpOut;
  logic [WIDTH-1:0]    ALUResult;
  logic                ALUZero;
  modport slave (
    input  Req0, Op0, A0, B0, Req1, Op1, A1, B1, ALUResult, ALUZero,
    output Ack0, Ack1, ResultOut, ZeroOut, Busy, ALUIn1, ALUIn2, ALUOpOut
  );
  modport master (
    output Req0, Op0, A0, B0, Req1, Op1, A1, B1, ALUResult, ALUZero,
    input  Ack0, Ack1, ResultOut, ZeroOut, Busy, ALUIn1, ALUIn2, ALUOpOut
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one clocked ALU between two requesters
module alu_arbiter #(
  parameter int WIDTH = 16,
  parameter int OP_WIDTH = 3,
  parameter int ALU_LATENCY = 1
) (
  input logic CLK,
  input logic Reset,
  alu_arbiter_if.slave bus
);
  localparam int CW = $clog2(ALU_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t              state, state_nx;
  logic [OP_WIDTH-1:0] op_r;
  logic [WIDTH-1:0]    a_r, b_r;
  logic [CW-1:0]       cnt;
  logic                win, ptr, grant1;
  assign grant1 = bus.Req1 & (~bus.Req0 | ~ptr);
  // next state, acks and ALU drive; ALU sees zeros while idle
  always_comb begin
    state_nx = state == IDLE ? ((bus.Req0 | bus.Req1) ? EXEC : IDLE)
             : state == EXEC ? (cnt == '0 ? DONE : EXEC) : IDLE;
    bus.Ack0 = state == DONE && !win;
    bus.Ack1 = state == DONE && win;
    bus.Busy = state != IDLE;
    bus.ALUIn1 = state == IDLE ? '0 : a_r;
    bus.ALUIn2 = state == IDLE ? '0 : b_r;
    bus.ALUOpOut = state == IDLE ? '0 : op_r;
  end
  // state register
  always_ff @(posedge CLK) begin
    if (!Reset) state <= IDLE;
    else state <= state_nx;
  end
  // operand latch, latency countdown, result capture and round-robin pointer
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      cnt <= '0;
      win <= 1'b0;
      ptr <= 1'b1;
      bus.ResultOut <= '0;
      bus.ZeroOut <= 1'b0;
    end else if (state == IDLE && (bus.Req0 | bus.Req1)) begin
      win <= grant1;
      op_r <= grant1 ? bus.Op1 : bus.Op0;
      a_r <= grant1 ? bus.A1 : bus.A0;
      b_r <= grant1 ? bus.B1 : bus.B0;
      cnt <= CW'(ALU_LATENCY);
    end else if (state == EXEC) begin
      if (cnt == '0) begin
        bus.ResultOut <= bus.ALUResult;
        bus.ZeroOut <= bus.ALUZero;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (state == DONE) begin
      ptr <= win;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with clocked ALU models for latency 1 and 2
module tb_alu_arbiter;
  logic CLK = 1'b0;
  logic Reset = 1'b0;
  int cyc = 0;
  int vectors = 0;
  int fails = 0;
  typedef struct {
    bit p;
    logic [15:0] r;
    logic z;
    int c;
  } exp_t;
  exp_t q1[$];
  exp_t q2[$];
  logic [15:0] s2;
  alu_arbiter_if #(.WIDTH(16), .OP_WIDTH(3)) i1 ();
  alu_arbiter_if #(.WIDTH(16), .OP_WIDTH(3)) i2 ();
  alu_arbiter #(.WIDTH(16), .OP_WIDTH(3), .ALU_LATENCY(1)) dut1 (.CLK(CLK), .Reset(Reset), .bus(i1));
  alu_arbiter #(.WIDTH(16), .OP_WIDTH(3), .ALU_LATENCY(2)) dut2 (.CLK(CLK), .Reset(Reset), .bus(i2));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    return op == 3'd0 ? a + b : op == 3'd1 ? a - b : op == 3'd3 ? (a | b) : op == 3'd4 ? (a & b) : 16'h0;
  endfunction
  // behavioural ALUs: one register stage for dut1, two for dut2
  always @(posedge CLK) begin
    i1.ALUResult <= alu_f(i1.ALUOpOut, i1.ALUIn1, i1.ALUIn2);
    i1.ALUZero <= alu_f(i1.ALUOpOut, i1.ALUIn1, i1.ALUIn2) == 16'h0;
    s2 <= alu_f(i2.ALUOpOut, i2.ALUIn1, i2.ALUIn2);
    i2.ALUResult <= s2;
    i2.ALUZero <= s2 == 16'h0;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask
  task automatic mon(input int d, input logic a0, input logic a1, input logic [15:0] r, input logic z);
    exp_t e;
    if (!(a0 || a1)) return;
    vectors++;
    if ((d == 1 ? q1.size() : q2.size()) == 0) begin
      fails++;
      $display("FAIL dut%0d unexpected_ack: got ack0=%b ack1=%b at cycle %0d, required no ack", d, a0, a1, cyc);
      return;
    end
    e = d == 1 ? q1.pop_front() : q2.pop_front();
    if ((a0 && a1) || a1 !== e.p || r !== e.r || z !== e.z || cyc !== e.c) begin
      fails++;
      $display("FAIL dut%0d ack: got ack0=%b ack1=%b result=%h zero=%b cycle=%0d, required port=%0d result=%h zero=%b cycle=%0d",
               d, a0, a1, r, z, cyc, e.p, e.r, e.z, e.c);
    end
  endtask
  // monitor: every ack is popped against the scoreboard
  always @(negedge CLK) begin
    mon(1, i1.Ack0, i1.Ack1, i1.ResultOut, i1.ZeroOut);
    mon(2, i2.Ack0, i2.Ack1, i2.ResultOut, i2.ZeroOut);
  end
  task automatic push1(input bit p, input logic [15:0] r, input logic z, input int c);
    exp_t e;
    e.p = p;
    e.r = r;
    e.z = z;
    e.c = c;
    q1.push_back(e);
  endtask
  task automatic drive(input bit p, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    if (p) begin
      i1.Op1 = op; i1.A1 = a; i1.B1 = b; i1.Req1 = 1'b1;
    end else begin
      i1.Op0 = op; i1.A0 = a; i1.B0 = b; i1.Req0 = 1'b1;
    end
    do begin
      @(negedge CLK);
      n++;
    end while (!(p ? i1.Ack1 : i1.Ack0) && n < 40);
    if (n >= 40) begin
      vectors++;
      fails++;
      $display("FAIL ack_timeout port%0d: got no ack in 40 cycles, required an ack", p);
    end
    @(posedge CLK);
    #1;
    if (p) i1.Req1 = 1'b0;
    else i1.Req0 = 1'b0;
  endtask
  task automatic do_reset();
    @(posedge CLK);
    #1 Reset = 1'b0;
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b1;
  endtask
  initial begin
    int k;
    int n;
    exp_t e;
    {i1.Req0, i1.Req1, i2.Req0, i2.Req1} = '0;
    {i1.Op1, i1.A1, i1.B1, i2.Op0, i2.A0, i2.B0, i2.Op1, i2.A1, i2.B1} = '0;
    i1.Req0 = 1'b1; i1.Op0 = 3'd3; i1.A0 = 16'd5; i1.B0 = 16'd6;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ack0", 32'(i1.Ack0), 0);
    chk("rst_ack1", 32'(i1.Ack1), 0);
    chk("rst_busy", 32'(i1.Busy), 0);
    chk("rst_result", 32'(i1.ResultOut), 0);
    chk("rst_aluop", 32'(i1.ALUOpOut), 0);
    chk("rst_aluin1", 32'(i1.ALUIn1), 0);
    chk("rst_busy2", 32'(i2.Busy), 0);
    @(posedge CLK);
    #1 Reset = 1'b1; i1.Req0 = 1'b0;
    @(posedge CLK);
    #1 k = cyc;
    push1(0, 16'd43, 1'b0, k + 3);
    drive(0, 3'd0, 16'd15, 16'd28);
    do_reset();
    k = cyc;
    push1(0, 16'd0, 1'b1, k + 3);
    push1(1, 16'd3, 1'b0, k + 7);
    fork
      drive(0, 3'd1, 16'd1, 16'd1);
      drive(1, 3'd3, 16'd1, 16'd2);
    join
    k = cyc;
    push1(0, 16'd4, 1'b0, k + 3);
    drive(0, 3'd0, 16'd2, 16'd2);
    k = cyc;
    push1(1, 16'hFFF8, 1'b0, k + 3);
    push1(0, 16'd1, 1'b0, k + 7);
    fork
      drive(0, 3'd4, 16'hFFF1, 16'd3);
      drive(1, 3'd0, 16'hFFFD, 16'hFFFB);
    join
    do_reset();
    k = cyc;
    push1(0, 16'd3, 1'b0, k + 3);
    push1(1, 16'd5, 1'b0, k + 7);
    push1(0, 16'd10, 1'b0, k + 11);
    push1(1, 16'd9, 1'b0, k + 15);
    fork
      begin
        drive(0, 3'd0, 16'd1, 16'd2);
        drive(0, 3'd0, 16'd5, 16'd5);
      end
      begin
        drive(1, 3'd1, 16'd9, 16'd4);
        drive(1, 3'd3, 16'd8, 16'd1);
      end
    join
    chk("pre_abort_result", 32'(i1.ResultOut), 32'd9);
    i1.Op1 = 3'd0; i1.A1 = 16'd7; i1.B1 = 16'd7; i1.Req1 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_busy_exec", 32'(i1.Busy), 1);
    Reset = 1'b0; i1.Req1 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_busy", 32'(i1.Busy), 0);
    chk("abort_ack1", 32'(i1.Ack1), 0);
    chk("abort_result", 32'(i1.ResultOut), 0);
    @(posedge CLK);
    #1 Reset = 1'b1;
    repeat (5) @(posedge CLK);
    #1 k = cyc;
    e.p = 1'b1; e.r = 16'd17; e.z = 1'b0; e.c = k + 4;
    q2.push_back(e);
    i2.Op1 = 3'd1; i2.A1 = 16'd13; i2.B1 = 16'hFFFC; i2.Req1 = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!i2.Ack1 && n < 40);
    if (n >= 40) begin
      vectors++;
      fails++;
      $display("FAIL ack_timeout dut2: got no ack in 40 cycles, required an ack");
    end
    @(posedge CLK);
    #1 i2.Req1 = 1'b0;
    repeat (4) @(posedge CLK);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
